// File: rtl/uart_time_pkg.sv
// Shared types and constants for the ASCII time-stream receiver.
// Holds the bit-FSM state encoding and the digit-range helpers.
package uart_time_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam int         FRAME_BYTES = 4;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

    function automatic logic [3:0] bcd_of(input logic [7:0] b);
        return b[3:0];
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser feeding a mid-bit sampling FSM.
// Emits one-cycle byte_ok / frm_err pulses when the stop bit is sampled.
module uart_rx_byte
    import uart_time_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       frm_err,
    output logic       active
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       sync_r;
    logic             rx_s;
    rx_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic [7:0]       rx_byte_r;
    logic             byte_ok_r;
    logic             frm_err_r;

    assign rx_s = sync_r[1];

    // Synchroniser, bit timing and byte capture; the stop bit is judged at its
    // midpoint so a following start edge is caught even with one stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r    <= 2'b11;
            state_r   <= IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            rx_byte_r <= 8'h00;
            byte_ok_r <= 1'b0;
            frm_err_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], rxd};
            byte_ok_r <= 1'b0;
            frm_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                    if (!rx_s) begin
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r   <= '0;
                        state_r <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= '0;
                        shift_r <= {rx_s, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
                            state_r   <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= IDLE;
                        if (rx_s) begin
                            byte_ok_r <= 1'b1;
                            rx_byte_r <= shift_r;
                        end else begin
                            frm_err_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rx_byte = rx_byte_r;
    assign byte_ok = byte_ok_r;
    assign frm_err = frm_err_r;
    assign active  = (state_r != IDLE);

endmodule

// File: rtl/uart_time_rx.sv
// ASCII time-stream receiver: four decimal digits per frame become BCD outputs.
// Optional inter-byte idle timeout is enabled with `define RX_TIMEOUT_EN.
module uart_time_rx
    import uart_time_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_CLKS = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [1:0] IDX_LAST     = 2'(FRAME_BYTES - 1);

    logic [7:0] rx_byte_s;
    logic       byte_ok_s;
    logic       frm_err_s;
    logic       active_s;
    logic       timeout_hit_s;

    logic [1:0] idx_r;
    logic [3:0] slot_r [0:FRAME_BYTES-2];
    logic [3:0] digit0_r;
    logic [3:0] digit1_r;
    logic [3:0] digit2_r;
    logic [3:0] digit3_r;
    logic       frame_valid_r;
    logic       frame_err_r;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk    (clk),
        .reset  (reset),
        .rxd    (rxd),
        .rx_byte(rx_byte_s),
        .byte_ok(byte_ok_s),
        .frm_err(frm_err_s),
        .active (active_s)
    );

`ifdef RX_TIMEOUT_EN
    localparam int            TO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [TO_W-1:0] idle_cnt_r;
    logic            counting_s;

    assign counting_s    = (idx_r != 2'd0) && !active_s && !byte_ok_s && !frm_err_s;
    assign timeout_hit_s = counting_s && (idle_cnt_r == TO_LAST);

    // Idle time between bytes of a partial frame; any line activity restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_r <= '0;
        end else if (!counting_s || timeout_hit_s) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + TO_ONE;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Frame assembler: a framing error outranks everything, then received bytes,
    // then the idle timeout; errors always leave the displayed frame intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r         <= 2'd0;
            for (int i = 0; i < FRAME_BYTES - 1; i++) begin
                slot_r[i] <= 4'd0;
            end
            digit0_r      <= 4'd0;
            digit1_r      <= 4'd0;
            digit2_r      <= 4'd0;
            digit3_r      <= 4'd0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            if (frm_err_s) begin
                frame_err_r <= 1'b1;
                idx_r       <= 2'd0;
            end else if (byte_ok_s) begin
                if (!is_digit(rx_byte_s)) begin
                    frame_err_r <= 1'b1;
                    idx_r       <= 2'd0;
                end else if (idx_r == IDX_LAST) begin
                    digit0_r      <= slot_r[0];
                    digit1_r      <= slot_r[1];
                    digit2_r      <= slot_r[2];
                    digit3_r      <= bcd_of(rx_byte_s);
                    frame_valid_r <= 1'b1;
                    idx_r         <= 2'd0;
                end else begin
                    slot_r[idx_r] <= bcd_of(rx_byte_s);
                    idx_r         <= idx_r + 2'd1;
                end
            end else if (timeout_hit_s) begin
                frame_err_r <= 1'b1;
                idx_r       <= 2'd0;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    assign digit0      = digit0_r;
    assign digit1      = digit1_r;
    assign digit2      = digit2_r;
    assign digit3      = digit3_r;
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    // A just-received byte counts as busy until the assembler has consumed it.
    assign busy        = active_s || (idx_r != 2'd0) || byte_ok_s;

endmodule

// File: tb/tb_uart_time_rx.sv
// Bench for uart_time_rx: serial bytes driven bit by bit, results compared
// against a queue-based model of the frame rules.
module tb_uart_time_rx;

    localparam int CLK_HZ  = 1_600_000;
    localparam int BAUD    = 100_000;
    localparam int CPB     = CLK_HZ / BAUD;
    localparam int TIMEOUT = 3000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       frame_valid, frame_err, busy;

    uart_time_rx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .TIMEOUT_CLKS(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int exp_valid = 0;
    int exp_err = 0;
    logic [3:0] exp_d [4];
    int pend[$];

    // Output pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
        if (frame_valid && frame_err) n_both++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_d[i] = 4'd0;
        pend.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            pend.delete();
            exp_err++;
        end else if (b >= 8'h30 && b <= 8'h39) begin
            pend.push_back(int'(b) - 48);
            if (pend.size() == 4) begin
                for (int i = 0; i < 4; i++) exp_d[i] = 4'(pend[i]);
                pend.delete();
                exp_valid++;
            end
        end else begin
            pend.delete();
            exp_err++;
        end
    endtask

    // A bad stop bit is held low past its midpoint, then released.
    task automatic xfer(input logic [7:0] b, input bit stop_ok);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        if (stop_ok) begin
            rxd = 1'b1;
            tick(CPB);
        end else begin
            rxd = 1'b0;
            tick(CPB / 2 + 4);
            rxd = 1'b1;
            tick(2 * CPB);
        end
        model_byte(b, stop_ok);
    endtask

    task automatic settle_check(input string tag);
        tick(2 * CPB);
        check({tag, "/valid_count"}, n_valid, exp_valid);
        check({tag, "/err_count"}, n_err, exp_err);
        check({tag, "/digits"}, {digit3, digit2, digit1, digit0},
              {exp_d[3], exp_d[2], exp_d[1], exp_d[0]});
        check({tag, "/busy"}, busy, (pend.size() != 0));
    endtask

    initial begin
        logic [7:0] b;
        int r;
        model_reset();
        tick(3);
        check("reset/digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check("reset/valid", frame_valid, 1'b0);
        check("reset/err", frame_err, 1'b0);
        check("reset/busy", busy, 1'b0);
        reset = 1'b0;
        tick(4);

        xfer(8'h31, 1'b1); xfer(8'h32, 1'b1); xfer(8'h33, 1'b1); xfer(8'h34, 1'b1);
        settle_check("frame_1234");

        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        settle_check("glitch");

        xfer(8'h31, 1'b1); xfer(8'h32, 1'b1); xfer(8'h41, 1'b1);
        settle_check("non_digit");
        xfer(8'h30, 1'b1); xfer(8'h39, 1'b1); xfer(8'h35, 1'b1); xfer(8'h39, 1'b1);
        settle_check("frame_0959");

        xfer(8'h37, 1'b0);
        settle_check("bad_stop");
        xfer(8'h32, 1'b1); xfer(8'h33, 1'b1); xfer(8'h35, 1'b1); xfer(8'h39, 1'b1);
        settle_check("frame_2359");

        xfer(8'h38, 1'b1); xfer(8'h37, 1'b1);
        b = 8'h36;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        reset = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        check("midreset/digits", {digit3, digit2, digit1, digit0}, 16'h0000);
        check("midreset/valid", frame_valid, 1'b0);
        check("midreset/err", frame_err, 1'b0);
        check("midreset/busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2);
        xfer(8'h30, 1'b1); xfer(8'h30, 1'b1); xfer(8'h30, 1'b1); xfer(8'h31, 1'b1);
        settle_check("frame_0001");

        for (int n = 0; n < 48; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                xfer(8'(8'h30 + $urandom_range(0, 9)), 1'b1);
            end else if (r == 7) begin
                b = 8'($urandom_range(0, 245));
                if (b >= 8'h30) b = b + 8'd10;
                xfer(b, 1'b1);
            end else if (r == 8) begin
                xfer(8'($urandom_range(0, 255)), 1'b0);
            end else begin
                tick($urandom_range(1, 40));
            end
            if ((n % 8) == 7) settle_check("random");
        end

        xfer(8'h00, 1'b1);
        xfer(8'h31, 1'b1); xfer(8'h32, 1'b1);
        tick(TIMEOUT + 100);
`ifdef RX_TIMEOUT_EN
        exp_err++;
        pend.delete();
`endif
        check("timeout/err_count", n_err, exp_err);
        check("timeout/busy", busy, (pend.size() != 0));
        check("exclusive_pulses", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
